// File: rtl/eth_pause_tx_pkg.sv
// Shared constants and types for the 802.3x PAUSE frame generator.
package eth_pause_tx_pkg;

  localparam logic [15:0] ETHERTYPE_MAC_CTRL = 16'h8808;
  localparam logic [15:0] OPCODE_PAUSE       = 16'h0001;
  localparam logic [47:0] PAUSE_DEST_MAC     = 48'h0180C2000001;
  localparam int unsigned PAUSE_HDR_LEN      = 18;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  typedef enum logic {
    PT_XON,
    PT_XOFF
  } pause_t;

endpackage

// File: rtl/eth_pause_tx.sv
// MAC Control PAUSE frame source: XOFF on request assertion plus periodic
// refreshes while held, XON on release; 8-bit AXI-stream output, pre-padded.
module eth_pause_tx
  import eth_pause_tx_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 60,
  parameter logic [47:0] DEST_MAC  = PAUSE_DEST_MAC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_req,
  input  logic [15:0] pause_quanta,
  input  logic [15:0] refresh_period,
  input  logic [47:0] src_mac,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        pause_sent
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_q;
  logic        r_pend;
  pause_t      r_pend_type;
  logic [15:0] r_tmr;
  logic [47:0] r_src;
  logic [15:0] r_quanta;
  logic [7:0]  r_idx;
  logic        r_sent;

  logic w_rise;
  logic w_fall;
  logic w_launch;
  logic w_load;
  logic w_expire;
  logic w_hs;
  logic w_last_hs;

  function automatic logic [7:0] frame_byte(input logic [7:0] i,
                                            input logic [47:0] src,
                                            input logic [15:0] q);
    int unsigned k;
    logic [7:0]  b;
    k = 32'(i);
    b = '0;
    if (k < 6)                  b = 8'(DEST_MAC >> (8 * (5 - k)));
    else if (k < 12)            b = 8'(src >> (8 * (11 - k)));
    else if (k < 14)            b = 8'(ETHERTYPE_MAC_CTRL >> (8 * (13 - k)));
    else if (k < 16)            b = 8'(OPCODE_PAUSE >> (8 * (15 - k)));
    else if (k < PAUSE_HDR_LEN) b = 8'(q >> (8 * (17 - k)));
    return b;
  endfunction

  assign w_rise    = pause_req & ~r_req_q;
  assign w_fall    = ~pause_req & r_req_q;
  assign w_launch  = (r_state == ST_IDLE) & r_pend;
  assign w_load    = w_launch & (r_pend_type == PT_XOFF);
  // A reload on XOFF launch restarts the countdown, so it suppresses expiry.
  assign w_expire  = r_req_q & ~w_load & (r_tmr == 16'd1) & (refresh_period != '0);
  assign w_hs      = m_axis_tvalid & m_axis_tready;
  assign w_last_hs = w_hs & m_axis_tlast;

  assign m_axis_tvalid = (r_state == ST_SEND);
  assign m_axis_tlast  = (r_state == ST_SEND) & (r_idx == 8'(FRAME_LEN - 1));
  assign m_axis_tdata  = (r_state == ST_SEND) ? frame_byte(r_idx, r_src, r_quanta) : '0;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (r_state == ST_SEND) | r_pend;
  assign pause_sent    = r_sent;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (r_pend)    w_state_nxt = ST_SEND;
      ST_SEND: if (w_last_hs) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_q     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_type <= PT_XON;
      r_tmr       <= '0;
      r_src       <= '0;
      r_quanta    <= '0;
      r_idx       <= '0;
      r_sent      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_q <= pause_req;
      r_sent  <= w_last_hs;

      if (w_launch) begin
        r_src    <= src_mac;
        r_quanta <= (r_pend_type == PT_XOFF) ? pause_quanta : '0;
      end

      if (w_last_hs)  r_idx <= '0;
      else if (w_hs)  r_idx <= r_idx + 8'd1;

      // Single pending slot: launch clears it, later events overwrite, XON last.
      if (w_launch) r_pend <= 1'b0;
      if (w_expire | w_rise) begin
        r_pend      <= 1'b1;
        r_pend_type <= PT_XOFF;
      end
      if (w_fall) begin
        r_pend      <= 1'b1;
        r_pend_type <= PT_XON;
      end

      if (!r_req_q)           r_tmr <= '0;
      else if (w_load)        r_tmr <= refresh_period;
      else if (r_tmr != '0)   r_tmr <= r_tmr - 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_pause_tx.sv
// Scoreboard bench for eth_pause_tx: an event-level model queues expected
// frames at launch; a negedge monitor reassembles output frames and compares.
module tb_eth_pause_tx;

  localparam int unsigned FL   = 60;
  localparam logic [47:0] DMAC = 48'h0180C2000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause_req = 1'b0;
  logic        tready = 1'b1;
  logic [15:0] quanta = '0;
  logic [15:0] period = '0;
  logic [47:0] src = '0;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, busy, sent;

  always #5 clk = ~clk;

  eth_pause_tx #(.FRAME_LEN(FL), .DEST_MAC(DMAC)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_quanta(quanta),
    .refresh_period(period), .src_mac(src),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .pause_sent(sent)
  );

  typedef struct {
    logic [47:0] src;
    logic [15:0] q;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  bit          bp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: request level, pending slot, refresh deadline, frame-in-flight.
  bit          m_req = 0, m_pend = 0, m_pxoff = 0, m_send = 0, m_sent = 0;
  bit          m_due_v = 0;
  int unsigned m_due = 0, m_cnt = 0;
  bit          launch, rise, fall, expire, ldx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 0; m_pend = 0; m_pxoff = 0; m_send = 0; m_sent = 0;
      m_due_v = 0; m_cnt = 0;
      sb.delete();
    end else begin
      cyc++;
      rise   = pause_req && !m_req;
      fall   = !pause_req && m_req;
      launch = !m_send && m_pend;
      ldx    = launch && m_pxoff;
      expire = m_req && m_due_v && (cyc == m_due) && (period != 0) && !ldx;
      m_sent = 0;
      if (launch) begin
        sb.push_back('{src, m_pxoff ? quanta : 16'h0000, cyc});
        m_send = 1;
        m_cnt  = 0;
      end else if (m_send && tready) begin
        m_cnt++;
        if (m_cnt == FL) begin
          m_send = 0;
          m_sent = 1;
        end
      end
      if (!m_req) m_due_v = 0;
      else if (ldx) begin
        m_due_v = 1;
        m_due   = cyc + 32'(period);
      end else if (expire) m_due_v = 0;
      if (launch) m_pend = 0;
      if (expire || rise) begin m_pend = 1; m_pxoff = 1; end
      if (fall)           begin m_pend = 1; m_pxoff = 0; end
      m_req = pause_req;
    end
  end

  // Monitor
  logic [7:0]  got[FL];
  logic [7:0]  last_frame[FL];
  logic [15:0] last_q = '0;
  logic [8*18-1:0] hdr;
  logic [7:0]  expb;
  int unsigned idx = 0, frames = 0, sent_pulses = 0, start_cyc = 0, nbytes_bad;
  bit          started = 0, p_stall = 0;
  logic [7:0]  p_data;
  logic        p_last;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      idx = 0; started = 0; p_stall = 0;
    end else begin
      chk("tvalid", tvalid, m_send);
      chk("busy", busy, m_send || m_pend);
      chk("pause_sent", sent, m_sent);
      chk("tuser", tuser, 0);
      if (sent) sent_pulses++;
      if (p_stall && tvalid) begin
        chk("stall tdata stable", tdata, p_data);
        chk("stall tlast stable", tlast, p_last);
      end
      if (tvalid && !started) begin
        started   = 1;
        start_cyc = cyc;
      end
      if (tvalid && tready) begin
        got[idx] = tdata;
        chk("tlast position", tlast, idx == FL - 1);
        if (idx == FL - 1 || tlast) begin
          if (sb.size() == 0) chk("unexpected frame", 1, 0);
          else begin
            e   = sb.pop_front();
            hdr = {DMAC, e.src, 16'h8808, 16'h0001, e.q};
            nbytes_bad = 0;
            for (int i = 0; i < FL; i++) begin
              expb = (i < 18) ? 8'(hdr >> (8 * (17 - i))) : 8'h00;
              if (got[i] !== expb) nbytes_bad++;
            end
            chk("frame byte errors", nbytes_bad, 0);
            chk("frame start cycle", start_cyc, e.cyc);
          end
          frames++;
          last_q     = {got[16], got[17]};
          last_frame = got;
          idx        = 0;
          started    = 0;
        end else idx++;
      end
      p_stall = tvalid && !tready;
      p_data  = tdata;
      p_last  = tlast;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tready = bp ? 1'($urandom % 2) : 1'b1;
    end
  endtask

  logic [7:0]  lit[18];
  int unsigned f0, diffs;

  initial begin
    lit = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h01, 8'h88, 8'h08, 8'h00, 8'h01, 8'hFF, 8'hFF};
    step(3);
    chk("reset tvalid", tvalid, 0);
    chk("reset tlast", tlast, 0);
    chk("reset tdata", tdata, 0);
    chk("reset busy", busy, 0);
    chk("reset pause_sent", sent, 0);
    rst = 1'b0;
    step(2);

    // Basic XOFF with fixed header check
    quanta = 16'hFFFF; src = 48'h020000000001; pause_req = 1'b1;
    step(FL + 10);
    chk("frames after first xoff", frames, 1);
    chk("pause_sent pulse count", sent_pulses, 1);
    diffs = 0;
    for (int i = 0; i < FL; i++)
      if (last_frame[i] !== ((i < 18) ? lit[i] : 8'h00)) diffs++;
    chk("xoff literal byte diffs", diffs, 0);

    pause_req = 1'b0;
    step(FL + 10);
    chk("frames after xon", frames, 2);
    chk("xon quanta", last_q, 16'h0000);

    // Refresh while held
    f0 = frames; period = 16'd200; pause_req = 1'b1;
    step(700);
    chk("refresh xoff frames", frames - f0, 4);
    pause_req = 1'b0;
    step(80);
    chk("xon after refresh quanta", last_q, 16'h0000);
    period = 16'd0;

    // Short pulses, second one overwriting pending during a frame
    f0 = frames;
    pause_req = 1'b1; step(3); pause_req = 1'b0;
    step(70);
    pause_req = 1'b1; step(3); pause_req = 1'b0;
    step(200);
    chk("pulse frames", frames - f0, 3);
    chk("overwrite leaves xon", last_q, 16'h0000);

    // Randomized traffic with backpressure
    bp = 1'b1;
    repeat (40) begin
      quanta    = 16'($urandom);
      src       = {16'($urandom), $urandom};
      period    = ($urandom % 3 == 0) ? 16'd0 : 16'(50 + $urandom % 200);
      pause_req = 1'($urandom % 2);
      step(1 + $urandom % 150);
    end
    pause_req = 1'b0;
    step(400);
    bp = 1'b0; period = 16'd0;
    step(10);

    // Reset mid-frame
    quanta = 16'h1234; pause_req = 1'b1;
    for (int i = 0; i < 200 && idx != 30; i++) step(1);
    chk("reached byte 30", idx, 30);
    #2 rst = 1'b1;
    #1;
    chk("tvalid drops on reset", tvalid, 0);
    chk("no tlast on reset", tlast, 0);
    step(2);
    rst = 1'b0;
    f0 = frames;
    step(FL + 10);
    chk("frame after reset", frames - f0, 1);
    chk("post-reset xoff quanta", last_q, 16'h1234);

    // Refresh disabled: one XOFF over a long hold
    pause_req = 1'b0;
    step(100);
    f0 = frames;
    pause_req = 1'b1;
    step(10000);
    chk("no-refresh frame count", frames - f0, 1);
    pause_req = 1'b0;
    step(100);
    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
